// File: rtl/usb_rst_sequencer.sv
// Avalon-MM slave that sequences the external USB controller reset pin:
// hold low for PULSE_LEN cycles, release, wait SETTLE_LEN cycles, then flag done.
module usb_rst_sequencer #(
    parameter int CNT_W      = 24,
    parameter int DEF_PULSE  = 50000,
    parameter int DEF_SETTLE = 100000,
    parameter int AUTO_START = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        usb_rst_n,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ASSERT = 2'b01,
        ST_SETTLE = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] ONE_C        = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEF_PULSE_C  = CNT_W'(DEF_PULSE);
    localparam logic [CNT_W-1:0] DEF_SETTLE_C = CNT_W'(DEF_SETTLE);
    localparam state_e           RST_STATE    = (AUTO_START != 0) ? ST_ASSERT : ST_IDLE;
    localparam logic [CNT_W-1:0] RST_CNT      = (AUTO_START == 0) ? {CNT_W{1'b0}} :
                                                (DEF_PULSE_C == {CNT_W{1'b0}}) ? ONE_C : DEF_PULSE_C;

    // A programmed length of zero still yields a one-cycle phase.
    function automatic logic [CNT_W-1:0] load_len(input logic [CNT_W-1:0] len);
        return (len == {CNT_W{1'b0}}) ? ONE_C : len;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  pulse_len_q, pulse_len_d;
    logic [CNT_W-1:0]  settle_len_q, settle_len_d;
    logic              force_q, force_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              usb_rst_n_q, usb_rst_n_d;
    logic              irq_q, irq_d;
    logic              wr_s, wr_ctrl_s, start_s, abort_s;
    logic              unused_wdata_s;

    assign unused_wdata_s = ^writedata;

    // Register decode, sequencer next state and next registered outputs.
    always_comb begin
        wr_s         = chipselect & ~write_n;
        wr_ctrl_s    = wr_s & (address == 2'd0);
        start_s      = wr_ctrl_s & writedata[0];
        abort_s      = wr_ctrl_s & writedata[3];
        state_d      = state_q;
        cnt_d        = cnt_q;
        pulse_len_d  = pulse_len_q;
        settle_len_d = settle_len_q;
        force_d      = force_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        usb_rst_n_d  = 1'b0;

        if (wr_ctrl_s) begin
            force_d  = writedata[1];
            irq_en_d = writedata[2];
        end else begin
            force_d  = force_q;
            irq_en_d = irq_en_q;
        end
        if (wr_s && (address == 2'd1)) begin
            pulse_len_d = writedata[CNT_W-1:0];
        end else begin
            pulse_len_d = pulse_len_q;
        end
        if (wr_s && (address == 2'd2)) begin
            settle_len_d = writedata[CNT_W-1:0];
        end else begin
            settle_len_d = settle_len_q;
        end
        if (wr_s && (address == 2'd3) && writedata[1]) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        // Abort overrides everything, including a start in the same write.
        if (abort_s) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_d = ST_ASSERT;
                        cnt_d   = load_len(pulse_len_q);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = cnt_q;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_q <= ONE_C) begin
                        state_d = ST_SETTLE;
                        cnt_d   = load_len(settle_len_q);
                    end else begin
                        state_d = ST_ASSERT;
                        cnt_d   = cnt_q - ONE_C;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q <= ONE_C) begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                        cnt_d   = cnt_q - ONE_C;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end

        case (state_d)
            ST_IDLE:   usb_rst_n_d = ~force_d;
            ST_ASSERT: usb_rst_n_d = 1'b0;
            ST_SETTLE: usb_rst_n_d = 1'b1;
            default:   usb_rst_n_d = 1'b0;
        endcase
        irq_d = done_d & irq_en_d;
    end

    // State and configuration registers; reset drives the USB pin low at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RST_STATE;
            cnt_q        <= RST_CNT;
            pulse_len_q  <= DEF_PULSE_C;
            settle_len_q <= DEF_SETTLE_C;
            force_q      <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            usb_rst_n_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pulse_len_q  <= pulse_len_d;
            settle_len_q <= settle_len_d;
            force_q      <= force_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            usb_rst_n_q  <= usb_rst_n_d;
            irq_q        <= irq_d;
        end
    end

    // Zero-latency read mux; CTRL start/abort are write-only strobes.
    always_comb begin
        case (address)
            2'd0:    readdata = {29'd0, force_q, irq_en_q, 1'b0};
            2'd1:    readdata = 32'(pulse_len_q);
            2'd2:    readdata = 32'(settle_len_q);
            2'd3:    readdata = {28'd0, state_q, done_q, (state_q != ST_IDLE)};
            default: readdata = 32'd0;
        endcase
    end

    assign usb_rst_n = usb_rst_n_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Scoreboarded bench for usb_rst_sequencer: each sequence pushes its expected
// pulse/busy/done/irq outcome; a monitor measures every busy episode and compares.
module tb_usb_rst_sequencer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        usb_rst_n;
    logic        irq;

    usb_rst_sequencer #(
        .CNT_W(24), .DEF_PULSE(10), .DEF_SETTLE(20), .AUTO_START(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .usb_rst_n(usb_rst_n), .irq(irq)
    );

    typedef struct {
        int pulse;
        int busy;
        bit done;
        bit irq;
    } exp_t;

    typedef struct {
        int          gap;
        logic [1:0]  addr;
        logic [31:0] data;
    } mid_t;

    exp_t sb_q[$];
    mid_t mids[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulse_m, settle_m;
    bit   done_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int len1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Reference: the pin is low for the first max(P,1) busy cycles, busy lasts
    // max(P,1)+max(S,1) cycles unless aborted after abort_w cycles.
    function automatic exp_t model_seq(input int p, input int s, input int abort_w,
                                       input bit done_before, input bit ie);
        exp_t e;
        int pl = len1(p);
        int tot = pl + len1(s);
        if (abort_w > 0 && abort_w < tot) begin
            e.busy  = abort_w;
            e.pulse = (abort_w < pl) ? abort_w : pl;
            e.done  = done_before;
        end else begin
            e.busy  = tot;
            e.pulse = pl;
            e.done  = 1'b1;
        end
        e.irq = e.done & ie;
        return e;
    endfunction

    // Writes land between a falling edge and the following rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        address = 2'd3; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        #1;
        address = a;
        #1;
        d = readdata;
        @(posedge clk);
        #1;
        address = 2'd3;
    endtask

    task automatic add_mid(input int gap, input logic [1:0] a, input logic [31:0] d);
        mid_t m;
        m.gap = gap; m.addr = a; m.data = d;
        mids.push_back(m);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        check("seq_drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Start a sequence, replay queued mid-sequence writes at their cycle offsets.
    task automatic do_seq(input int abort_w, input bit ie);
        exp_t e;
        int elapsed;
        e = model_seq(pulse_m, settle_m, abort_w, done_m, ie);
        sb_q.push_back(e);
        bus_write(2'd0, {29'd0, ie, 2'b01});
        elapsed = 0;
        foreach (mids[i]) begin
            repeat (mids[i].gap - elapsed - 1) @(posedge clk);
            bus_write(mids[i].addr, mids[i].data);
            elapsed = mids[i].gap;
        end
        mids.delete();
        wait_drain(e.busy + 6);
        done_m = e.done;
    endtask

    task automatic set_lens(input int p, input int s);
        bus_write(2'd1, 32'(p));
        bus_write(2'd2, 32'(s));
        pulse_m = p;
        settle_m = s;
    endtask

    // Monitor: measures each busy episode on STATUS and scores it on its end.
    initial begin
        int   bcnt = 0;
        int   pcnt = 0;
        bit   in_run = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_run = 1'b0; bcnt = 0; pcnt = 0;
            end else if (readdata[0]) begin
                in_run = 1'b1;
                bcnt++;
                if (!usb_rst_n) pcnt++;
            end else if (in_run) begin
                in_run = 1'b0;
                if (sb_q.size() == 0) begin
                    check("unexpected_seq", 32'(bcnt), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("pulse_len", 32'(pcnt), 32'(e.pulse));
                    check("busy_len", 32'(bcnt), 32'(e.busy));
                    check("done_at_end", {31'd0, readdata[1]}, {31'd0, e.done});
                    check("irq_at_end", {31'd0, irq}, {31'd0, e.irq});
                    check("rst_n_at_end", {31'd0, usb_rst_n}, 32'd1);
                end
                bcnt = 0; pcnt = 0;
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int p, s, tot, g, abort_w, newp;
        bit ie;

        reset_n = 1'b0; address = 2'd3; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        pulse_m = 10; settle_m = 20; done_m = 1'b0;
        sb_q.push_back(model_seq(10, 20, 0, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("rst_usb_rst_n", {31'd0, usb_rst_n}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_status", readdata, 32'h5);
        @(posedge clk);
        #2 reset_n = 1'b1;
        bus_read(2'd1, rd); check("def_pulse", rd, 32'd10);
        bus_read(2'd2, rd); check("def_settle", rd, 32'd20);
        bus_read(2'd0, rd); check("def_ctrl", rd, 32'd0);
        wait_drain(40);
        done_m = 1'b1;
        bus_read(2'd3, rd); check("auto_status", rd, 32'h2);

        // 5/3 with interrupt, then W1C clears irq.
        set_lens(5, 3);
        do_seq(0, 1'b1);
        @(negedge clk); check("irq_high", {31'd0, irq}, 32'd1);
        bus_read(2'd3, rd); check("status_done", rd, 32'h2);
        bus_write(2'd3, 32'h2);
        @(negedge clk); check("irq_cleared", {31'd0, irq}, 32'd0);
        done_m = 1'b0;

        // Restart and length change while busy do not disturb the running pulse.
        set_lens(100, 3);
        add_mid(10, 2'd0, 32'h1);
        add_mid(11, 2'd1, 32'd2);
        do_seq(0, 1'b0);
        pulse_m = 2;
        do_seq(0, 1'b0);

        // Abort four cycles into SETTLE.
        bus_write(2'd3, 32'h2); done_m = 1'b0;
        set_lens(3, 10);
        add_mid(7, 2'd0, 32'h8);
        do_seq(7, 1'b0);
        bus_read(2'd3, rd); check("abort_status", rd, 32'h0);

        // Zero lengths behave as one; force in IDLE.
        set_lens(0, 0);
        do_seq(0, 1'b0);
        bus_write(2'd0, 32'h2);
        @(negedge clk); check("force_low", {31'd0, usb_rst_n}, 32'd0);
        bus_write(2'd0, 32'h6);
        bus_read(2'd0, rd); check("ctrl_readback", rd, 32'h6);
        bus_write(2'd0, 32'h0);
        @(negedge clk); check("force_release", {31'd0, usb_rst_n}, 32'd1);

        // W1C on the completion edge: set wins.
        set_lens(2, 2);
        add_mid(4, 2'd3, 32'h2);
        do_seq(0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                p = $urandom_range(12, 0);
                s = $urandom_range(12, 0);
                set_lens(p, s);
            end
            if ($urandom_range(1, 0) == 1) begin
                bus_write(2'd3, 32'h2);
                done_m = 1'b0;
            end
            ie = 1'($urandom_range(1, 0));
            tot = len1(pulse_m) + len1(settle_m);
            abort_w = 0;
            newp = -1;
            case ($urandom_range(3, 0))
                0: begin
                    abort_w = $urandom_range(tot - 1, 1);
                    add_mid(abort_w, 2'd0, {28'd0, 1'b1, ie, 2'b00});
                end
                1: begin
                    g = $urandom_range(tot - 1, 1);
                    add_mid(g, 2'd0, {29'd0, ie, 2'b01});
                end
                2: begin
                    g = $urandom_range(tot - 1, 1);
                    newp = $urandom_range(12, 0);
                    add_mid(g, 2'd1, 32'(newp));
                end
                default: ;
            endcase
            do_seq(abort_w, ie);
            if (newp >= 0) pulse_m = newp;
        end

        // Reset pulse in the middle of SETTLE restarts the automatic sequence.
        set_lens(4, 10);
        bus_write(2'd0, 32'h1);
        repeat (6) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_rst_n", {31'd0, usb_rst_n}, 32'd0);
        pulse_m = 10; settle_m = 20; done_m = 1'b0;
        sb_q.push_back(model_seq(10, 20, 0, 1'b0, 1'b0));
        @(posedge clk);
        #2 reset_n = 1'b1;
        bus_read(2'd1, rd); check("midreset_pulse", rd, 32'd10);
        bus_read(2'd2, rd); check("midreset_settle", rd, 32'd20);
        wait_drain(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
